// File: rtl/bus_master_arb.sv
// ============================================================================
// Module   : bus_master_arb
// Summary  : Four-master round-robin bus arbiter with a master-side output mux.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_master_arb #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              m0_req_,
  input  logic              m1_req_,
  input  logic              m2_req_,
  input  logic              m3_req_,
  output logic              m0_grnt_,
  output logic              m1_grnt_,
  output logic              m2_grnt_,
  output logic              m3_grnt_,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic [ADDR_W-1:0] m3_addr,
  input  logic              m0_as_,
  input  logic              m1_as_,
  input  logic              m2_as_,
  input  logic              m3_as_,
  input  logic              m0_rw,
  input  logic              m1_rw,
  input  logic              m2_rw,
  input  logic              m3_rw,
  input  logic [DATA_W-1:0] m0_wr_data,
  input  logic [DATA_W-1:0] m1_wr_data,
  input  logic [DATA_W-1:0] m2_wr_data,
  input  logic [DATA_W-1:0] m3_wr_data,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_as_,
  output logic              s_rw,
  output logic [DATA_W-1:0] s_wr_data
);

  logic [1:0] owner_q;
  logic [1:0] owner_d;
  logic [3:0] req_n;
  logic [1:0] cand;
  logic       found;

  assign req_n = {m3_req_, m2_req_, m1_req_, m0_req_};

  // Owner keeps the bus while requesting; otherwise rotate from owner+1.
  // With nobody requesting the grant stays parked on the current owner.
  always_comb begin
    owner_d = owner_q;
    found   = 1'b0;
    cand    = owner_q;
    if (req_n[owner_q]) begin
      for (int i = 1; i < 4; i++) begin
        cand = owner_q + i[1:0];
        if (!found && !req_n[cand]) begin
          owner_d = cand;
          found   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      owner_q <= 2'd0;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign m0_grnt_ = (owner_q != 2'd0);
  assign m1_grnt_ = (owner_q != 2'd1);
  assign m2_grnt_ = (owner_q != 2'd2);
  assign m3_grnt_ = (owner_q != 2'd3);

  // Gating as_ with the owner's own req_ keeps a parked, idle owner off the bus.
  always_comb begin
    s_addr    = m0_addr;
    s_as_     = m0_as_ | m0_req_;
    s_rw      = m0_rw;
    s_wr_data = m0_wr_data;
    case (owner_q)
      2'd1: begin
        s_addr    = m1_addr;
        s_as_     = m1_as_ | m1_req_;
        s_rw      = m1_rw;
        s_wr_data = m1_wr_data;
      end
      2'd2: begin
        s_addr    = m2_addr;
        s_as_     = m2_as_ | m2_req_;
        s_rw      = m2_rw;
        s_wr_data = m2_wr_data;
      end
      2'd3: begin
        s_addr    = m3_addr;
        s_as_     = m3_as_ | m3_req_;
        s_rw      = m3_rw;
        s_wr_data = m3_wr_data;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
